l1_load_scheduler: RTL and testbench

//  Sequences the L1-signalling ring register and parameter decoder of the T2-MI packer.

---
 rtl/l1_load_scheduler_pkg.sv | 18 +
 rtl/l1_load_scheduler_if.sv | 32 +++
 rtl/l1_load_scheduler_staging_buffer.sv | 96 +++++++++
 rtl/l1_load_scheduler.sv | 144 ++++++++++++++
 tb/tb_l1_load_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_load_scheduler_pkg.sv
// Shared sizing, FSM encodings and helpers for the L1 load scheduler and its staging buffer.
// Build option L1_ERR_CNT_EN (see l1_load_scheduler) uses sat_inc16.
package l1_load_scheduler_pkg;

    localparam int L1_LEN_BYTES = 67;
    localparam int L1_PTR_W     = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } sched_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/l1_load_scheduler_if.sv
// Host byte stream, ring register/decoder strobes and assembler handshake of the L1 load scheduler.
// slave = scheduler side, master = surrounding environment.
interface l1_load_scheduler_if;
    logic [7:0] host_dat;
    logic       host_vld;
    logic       host_sop;
    logic       host_eop;
    logic       host_rdy;
    logic [7:0] l1_data_in;
    logic       l1_load;
    logic       l1_shift;
    logic [7:0] l1_data_out;
    logic       l1_req;
    logic [7:0] l1_out_dat;
    logic       l1_out_vld;
    logic       l1_out_rdy;
    logic       l1_out_last;
    logic       cfg_updated;
    logic       l1_valid;

    modport slave (
        input  host_dat, host_vld, host_sop, host_eop, l1_data_out, l1_req, l1_out_rdy,
        output host_rdy, l1_data_in, l1_load, l1_shift, l1_out_dat, l1_out_vld,
               l1_out_last, cfg_updated, l1_valid
    );

    modport master (
        output host_dat, host_vld, host_sop, host_eop, l1_data_out, l1_req, l1_out_rdy,
        input  host_rdy, l1_data_in, l1_load, l1_shift, l1_out_dat, l1_out_vld,
               l1_out_last, cfg_updated, l1_valid
    );
endinterface

// File: rtl/l1_load_scheduler_staging_buffer.sv
// Staging store for one L1 packet: length check on the host stream, pending flag, random-access read port.
// Host is back-pressured (wr_rdy_o=0) from a good EOP until load_done_i.
module l1_staging_buffer
    import l1_load_scheduler_pkg::*;
#(
    parameter int L1_LEN = L1_LEN_BYTES,
    parameter int PTR_W  = L1_PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       wr_dat_i,
    input  logic             wr_vld_i,
    input  logic             wr_sop_i,
    input  logic             wr_eop_i,
    output logic             wr_rdy_o,
    input  logic [PTR_W-1:0] rd_addr_i,
    output logic [7:0]       rd_dat_o,
    input  logic             load_done_i,
    output logic             pending_o,
    output logic             discard_o
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(L1_LEN - 1);

    logic [7:0]       mem_q [L1_LEN];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             active_q, active_d;
    logic             pending_q, pending_d;
    logic             discard_d;
    logic             we;
    logic [PTR_W-1:0] wr_addr;
    logic             take;

    assign wr_rdy_o  = !pending_q;
    assign take      = wr_vld_i & wr_rdy_o;
    assign pending_o = pending_q;
    assign discard_o = discard_d;
    assign rd_dat_o  = (rd_addr_i < PTR_W'(L1_LEN)) ? mem_q[rd_addr_i] : 8'h00;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        active_d  = active_q;
        pending_d = pending_q;
        discard_d = 1'b0;
        we        = 1'b0;
        wr_addr   = wr_ptr_q;
        if (load_done_i) pending_d = 1'b0;
        if (take) begin
            if (wr_sop_i) begin
                // An SOP while collecting throws away the partial packet.
                discard_d = active_q;
                we        = 1'b1;
                wr_addr   = '0;
                if (wr_eop_i) begin
                    active_d  = 1'b0;
                    wr_ptr_d  = '0;
                    discard_d = 1'b1;
                end else begin
                    active_d = 1'b1;
                    wr_ptr_d = PTR_W'(1);
                end
            end else if (active_q) begin
                we = 1'b1;
                if (wr_ptr_q == LAST_IDX) begin
                    active_d = 1'b0;
                    wr_ptr_d = '0;
                    if (wr_eop_i) pending_d = 1'b1;
                    else          discard_d = 1'b1;
                end else if (wr_eop_i) begin
                    active_d  = 1'b0;
                    wr_ptr_d  = '0;
                    discard_d = 1'b1;
                end else begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            active_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[wr_addr] <= wr_dat_i;
    end

endmodule

// File: rtl/l1_load_scheduler.sv
// Commits a staged L1 packet to the ring as one gap-free L1_LOAD burst and arbitrates it against full-rotation SHIFT bursts.
// Last host byte -> L1_LOAD in 2 cycles; L1_REQ -> L1_OUT_VALID in 1 cycle; SHIFT stalls on L1_OUT_READY; L1_ERR_CNT_EN adds l1_err_cnt_o.
module l1_load_scheduler
    import l1_load_scheduler_pkg::*;
#(
    parameter int L1_LEN = L1_LEN_BYTES,
    parameter int PTR_W  = L1_PTR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    l1_load_scheduler_if.slave  bus
`ifdef L1_ERR_CNT_EN
    ,
    output logic [15:0]         l1_err_cnt_o
`endif
);

    localparam logic [PTR_W-1:0] LEN_C  = PTR_W'(L1_LEN);
    localparam logic [PTR_W-1:0] LAST_C = PTR_W'(L1_LEN - 1);

    sched_state_e     state_q, state_d;
    logic [PTR_W-1:0] cnt_q, cnt_d;
    logic             load_q, load_d;
    logic [7:0]       data_q, data_d;
    logic             cfg_q, cfg_d;
    logic             valid_q, valid_d;
    logic             load_done;
    logic             pending;
    logic             discard;
    logic [7:0]       rd_dat;
    logic             out_vld;
    logic             shift;

    l1_staging_buffer #(.L1_LEN(L1_LEN), .PTR_W(PTR_W)) u_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_dat_i    (bus.host_dat),
        .wr_vld_i    (bus.host_vld),
        .wr_sop_i    (bus.host_sop),
        .wr_eop_i    (bus.host_eop),
        .wr_rdy_o    (bus.host_rdy),
        .rd_addr_i   (cnt_q),
        .rd_dat_o    (rd_dat),
        .load_done_i (load_done),
        .pending_o   (pending),
        .discard_o   (discard)
    );

    assign out_vld         = (state_q == ST_SHIFT);
    assign shift           = out_vld & bus.l1_out_rdy;
    assign bus.l1_out_vld  = out_vld;
    assign bus.l1_out_last = out_vld && (cnt_q == LAST_C);
    assign bus.l1_shift    = shift;
    assign bus.l1_out_dat  = bus.l1_data_out;
    assign bus.l1_load     = load_q;
    assign bus.l1_data_in  = data_q;
    assign bus.cfg_updated = cfg_q;
    assign bus.l1_valid    = valid_q;

    // Output strobes are registered, so the first LOAD byte is launched on the IDLE->LOAD edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_d    = 1'b0;
        data_d    = 8'h00;
        cfg_d     = 1'b0;
        valid_d   = valid_q;
        load_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    state_d = ST_LOAD;
                    load_d  = 1'b1;
                    data_d  = rd_dat;
                    cnt_d   = PTR_W'(1);
                end else if (bus.l1_req && valid_q) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (cnt_q == LEN_C) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    cfg_d     = 1'b1;
                    valid_d   = 1'b1;
                    load_done = 1'b1;
                end else begin
                    load_d = 1'b1;
                    data_d = rd_dat;
                    cnt_d  = cnt_q + PTR_W'(1);
                end
            end
            ST_SHIFT: begin
                if (shift) begin
                    if (cnt_q == LAST_C) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            data_q  <= 8'h00;
            cfg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            data_q  <= data_d;
            cfg_q   <= cfg_d;
            valid_q <= valid_d;
        end
    end

`ifdef L1_ERR_CNT_EN
    logic [15:0] err_q, err_d;

    assign err_d        = discard ? sat_inc16(err_q) : err_q;
    assign l1_err_cnt_o = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 16'h0000;
        else        err_q <= err_d;
    end
`else
    logic discard_unused;
    assign discard_unused = discard;
`endif

endmodule

// File: tb/tb_l1_load_scheduler.sv
// Directed bench for l1_load_scheduler with a behavioural ring register and decoder byte counter.
module tb_l1_load_scheduler;
    import l1_load_scheduler_pkg::*;

    localparam int N = L1_LEN_BYTES;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l1_load_scheduler_if bus();
`ifdef L1_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    l1_load_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef L1_ERR_CNT_EN
        ,
        .l1_err_cnt_o (err_cnt)
`endif
    );

    // Ring register: loads and rotations both advance it; head byte feeds back on rotate.
    logic [7:0] ring [N];
    always @(posedge clk) begin
        if (bus.l1_load || bus.l1_shift) begin
            for (int i = 0; i < N - 1; i++) ring[i] <= ring[i + 1];
            ring[N - 1] <= bus.l1_load ? bus.l1_data_in : ring[0];
        end
    end
    assign bus.l1_data_out = ring[0];

    logic [7:0] loadq [$];
    logic [7:0] shq [$];
    int         runq [$];
    int         lastq [$];
    int         run = 0, dcnt = 0, overlap = 0, vld_cycles = 0, cfg_cnt = 0;
    logic [7:0] nt2 = 8'h00;

    always @(negedge clk) begin
        if (bus.l1_load) begin
            loadq.push_back(bus.l1_data_in);
            if (dcnt == 16) nt2 = bus.l1_data_in;
            dcnt++;
            run++;
        end else begin
            if (run != 0) runq.push_back(run);
            run  = 0;
            dcnt = 0;
        end
        if (bus.l1_shift) begin
            shq.push_back(bus.l1_out_dat);
            if (bus.l1_out_last) lastq.push_back(shq.size() - 1);
        end
        if (bus.l1_load && bus.l1_shift) overlap++;
        if (bus.l1_out_vld) vld_cycles++;
        if (bus.cfg_updated) cfg_cnt++;
    end

    int n_pass = 0, n_total = 0;
    logic [7:0] pkt [N];
    logic [7:0] pkt_prev [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int cmp_q(input logic [7:0] q [$], input logic [7:0] exp_a [N]);
        int bad = 0;
        if (q.size() != N) return 1000 + q.size();
        for (int i = 0; i < N; i++) if (q[i] !== exp_a[i]) bad++;
        return bad;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] seed);
        for (int i = 0; i < N; i++) pkt[i] = 8'(i * 13) ^ seed;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit sop, input bit eop, input bit gap);
        bit acc = 0;
        if (gap) repeat ($urandom_range(0, 2)) step();
        bus.host_vld = 1'b1;
        bus.host_dat = d;
        bus.host_sop = sop;
        bus.host_eop = eop;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            acc = bus.host_rdy;
            step();
            if (acc) break;
        end
        if (!acc) check("host_accept_timeout", 0, 1);
        bus.host_vld = 1'b0;
        bus.host_sop = 1'b0;
        bus.host_eop = 1'b0;
    endtask

    task automatic send_good(input bit gaps);
        for (int i = 0; i < N; i++) send_byte(pkt[i], i == 0, i == N - 1, gaps);
    endtask

    // Called in the cycle holding LOAD byte 0; ends at the start of the cycle after CFG_UPDATED.
    task automatic wait_cfg();
        bit got = 0;
        int k;
        for (k = 0; k < 200; k++) begin
            step();
            @(negedge clk);
            if (bus.cfg_updated) begin
                got = 1;
                break;
            end
        end
        check("cfg_delay", got ? k + 1 : 0, 67);
        check("cfg_l1_valid", bus.l1_valid, 1);
        check("cfg_host_rdy", bus.host_rdy, 1);
        check("cfg_idle_gap", bus.l1_out_vld, 0);
        step();
    endtask

    // Called at the start of the cycle after the last host byte was taken.
    task automatic expect_load();
        @(negedge clk);
        check("lat_c1_load", bus.l1_load, 0);
        check("lat_c1_host_rdy", bus.host_rdy, 0);
        step();
        @(negedge clk);
        check("lat_c2_load", bus.l1_load, 1);
        check("lat_c2_byte0", bus.l1_data_in, pkt[0]);
        wait_cfg();
    endtask

    task automatic shift_burst(input bit toggle, input bit drop_req, output bit first_vld);
        bit done = 0;
        first_vld = 0;
        for (int c = 0; c < 400; c++) begin
            bus.l1_out_rdy = toggle ? (c % 2 == 0) : 1'b1;
            @(negedge clk);
            if (c == 0) first_vld = bus.l1_out_vld;
            if (bus.l1_out_vld && bus.l1_out_last && bus.l1_out_rdy) begin
                step();
                if (drop_req) bus.l1_req = 1'b0;
                done = 1;
                break;
            end
            step();
        end
        if (!done) check("shift_timeout", 0, 1);
    endtask

    task automatic check_shifts(input string tag, input logic [7:0] exp_a [N]);
        check({tag, "_bytes"}, cmp_q(shq, exp_a), 0);
        check({tag, "_last"}, (lastq.size() == 1) ? lastq[0] : -1, N - 1);
    endtask

    initial begin
        bit fv;
        bus.host_vld   = 1'b0;
        bus.host_dat   = 8'h00;
        bus.host_sop   = 1'b0;
        bus.host_eop   = 1'b0;
        bus.l1_req     = 1'b0;
        bus.l1_out_rdy = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_host_rdy", bus.host_rdy, 1);
        check("rst_load", bus.l1_load, 0);
        check("rst_data_in", bus.l1_data_in, 0);
        check("rst_out_vld", bus.l1_out_vld, 0);
        check("rst_out_last", bus.l1_out_last, 0);
        check("rst_cfg", bus.cfg_updated, 0);
        check("rst_l1_valid", bus.l1_valid, 0);
`ifdef L1_ERR_CNT_EN
        check("rst_err_cnt", err_cnt, 0);
`endif
        step();
        rst_n = 1'b1;
        step();

        // Request with nothing loaded is held off, then packet A loads and the held request shifts it out.
        bus.l1_req     = 1'b1;
        bus.l1_out_rdy = 1'b1;
        repeat (10) step();
        check("no_vld_before_load", vld_cycles, 0);
        fill(8'h5A);
        send_good(1'b1);
        expect_load();
        check("A_load_run", (runq.size() == 1) ? runq[0] : -1, N);
        check("A_load_bytes", cmp_q(loadq, pkt), 0);
        check("A_num_t2_frames", nt2, pkt[16]);
        check("A_cfg_pulses", cfg_cnt, 1);
        shift_burst(1'b1, 1'b1, fv);
        check("A_shift_first_vld", fv, 1);
        check_shifts("A_shift1", pkt);

        // Second request replays the same bytes.
        shq.delete();
        lastq.delete();
        bus.l1_req = 1'b1;
        @(negedge clk);
        check("A_req_idle_vld", bus.l1_out_vld, 0);
        step();
        shift_burst(1'b0, 1'b1, fv);
        check("A_shift2_first_vld", fv, 1);
        check_shifts("A_shift2", pkt);

        // Bad packets: early EOP, overlength, SOP restart; then the restarted packet B completes.
        loadq.delete();
        runq.delete();
        fill(8'h33);
        for (int i = 0; i <= 40; i++) send_byte(pkt[i], i == 0, i == 40, 1'b0);
        for (int i = 0; i <= N; i++) send_byte((i < N) ? pkt[i] : 8'hEE, i == 0, i == N, 1'b0);
        repeat (4) step();
        check("bad_no_load", loadq.size(), 0);
        check("bad_host_rdy", bus.host_rdy, 1);
        for (int i = 0; i < 10; i++) send_byte(pkt[i], i == 0, 1'b0, 1'b0);
        fill(8'hC3);
        send_good(1'b0);
        check("B_no_early_load", loadq.size(), 0);
        expect_load();
        check("B_load_bytes", cmp_q(loadq, pkt), 0);
`ifdef L1_ERR_CNT_EN
        check("B_err_cnt", err_cnt, 3);
`endif

        // Packet C completes during a stalled SHIFT of B; the held request waits for C's LOAD.
        pkt_prev = pkt;
        shq.delete();
        lastq.delete();
        loadq.delete();
        runq.delete();
        bus.l1_out_rdy = 1'b0;
        bus.l1_req     = 1'b1;
        step();
        step();
        fill(8'h77);
        send_good(1'b0);
        @(negedge clk);
        check("stall_no_shift", shq.size(), 0);
        check("stall_no_load", loadq.size(), 0);
        check("stall_host_rdy", bus.host_rdy, 0);
        step();
        shift_burst(1'b1, 1'b0, fv);
        check_shifts("B_shift", pkt_prev);
        @(negedge clk);
        check("gap_load", bus.l1_load, 0);
        check("gap_vld", bus.l1_out_vld, 0);
        step();
        @(negedge clk);
        check("C_load_first", bus.l1_load, 1);
        check("C_load_vld", bus.l1_out_vld, 0);
        wait_cfg();
        check("C_load_bytes", cmp_q(loadq, pkt), 0);
        shq.delete();
        lastq.delete();
        shift_burst(1'b0, 1'b1, fv);
        check("C_shift_first_vld", fv, 1);
        check_shifts("C_shift", pkt);

        // Reset during LOAD byte 30.
        fill(8'h19);
        send_good(1'b0);
        @(negedge clk);
        step();
        repeat (30) step();
        @(negedge clk);
        check("D_byte30", bus.l1_data_in, pkt[30]);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_load", bus.l1_load, 0);
        check("mid_rst_data", bus.l1_data_in, 0);
        check("mid_rst_l1_valid", bus.l1_valid, 0);
        check("mid_rst_host_rdy", bus.host_rdy, 1);
        check("mid_rst_cfg", bus.cfg_updated, 0);
`ifdef L1_ERR_CNT_EN
        check("mid_rst_err_cnt", err_cnt, 0);
`endif
        step();
        rst_n          = 1'b1;
        bus.l1_req     = 1'b1;
        bus.l1_out_rdy = 1'b1;
        step();
        vld_cycles = 0;
        repeat (5) step();
        check("post_rst_no_vld", vld_cycles, 0);

        // Fresh packet E after reset loads and shifts normally.
        loadq.delete();
        runq.delete();
        shq.delete();
        lastq.delete();
        fill(8'h6B);
        send_good(1'b1);
        expect_load();
        check("E_load_run", (runq.size() == 1) ? runq[0] : -1, N);
        check("E_load_bytes", cmp_q(loadq, pkt), 0);
        shift_burst(1'b0, 1'b1, fv);
        check("E_shift_first_vld", fv, 1);
        check_shifts("E_shift", pkt);

        check("load_shift_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
